filtered_ram_swap_control: RTL and testbench

Ping-pong filtered-projection store that sits directly upstream of the processing swap control. The filter stage writes one angle's filtered projection into a fill bank. This block then presents the oldest complete angle as the active bank, with two independent synchronous read ports (fr0/fr1), one per processing swappable. It answers the processing stage's next-angle request in the same cycle.

---
 rtl/filtered_ram_swap_control_pkg.sv | 30 +++
 rtl/filtered_ram_swap_control_if.sv | 34 +++
 rtl/filtered_ram_swap_control_bank.sv | 33 +++
 rtl/filtered_ram_swap_control.sv | 87 ++++++++
 tb/tb_filtered_ram_swap_control.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/filtered_ram_swap_control_pkg.sv
// Shared types and helpers for the ping-pong filtered-projection store.
// Widths follow the existing filter-path length macros.
`ifndef kFilteredDataLength
`define kFilteredDataLength 16
`endif
`ifndef kSLength
`define kSLength 4
`endif
`ifndef kAngleLength
`define kAngleLength 8
`endif

package filtered_ram_swap_control_pkg;
   localparam int DATA_W  = `kFilteredDataLength;
   localparam int S_W     = `kSLength;
   localparam int ANGLE_W = `kAngleLength;
   localparam int DEPTH   = 2**S_W;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2,
      BANK_ACTIVE  = 2'd3
   } bank_state_e;

   // Signed s to offset-binary word address: s = -DEPTH/2 lands on word 0.
   function automatic logic [S_W-1:0] s_to_addr(input logic signed [S_W-1:0] s);
      return {~s[S_W-1], s[S_W-2:0]};
   endfunction
endpackage

// File: rtl/filtered_ram_swap_control_if.sv
// Filter-side write bus and processing-side angle/read bus of the swap store.
interface filtered_ram_swap_control_if;
   import filtered_ram_swap_control_pkg::*;

   logic                      fl_we;
   logic signed [S_W-1:0]     fl_s;
   logic signed [DATA_W-1:0]  fl_val;
   logic                      fl_done;
   logic [ANGLE_W-1:0]        fl_angle;
   logic                      fl_last;
   logic                      fl_ready;
   logic                      fr_next_angle;
   logic                      fr_next_angle_ack;
   logic                      fr_has_next_angle;
   logic [ANGLE_W-1:0]        fr_angle;
   logic signed [S_W-1:0]     fr0_s_val;
   logic signed [S_W-1:0]     fr1_s_val;
   logic signed [DATA_W-1:0]  fr0_val;
   logic signed [DATA_W-1:0]  fr1_val;

   modport master (
      output fl_we, fl_s, fl_val, fl_done, fl_angle, fl_last,
             fr_next_angle, fr0_s_val, fr1_s_val,
      input  fl_ready, fr_next_angle_ack, fr_has_next_angle, fr_angle,
             fr0_val, fr1_val
   );

   modport slave (
      input  fl_we, fl_s, fl_val, fl_done, fl_angle, fl_last,
             fr_next_angle, fr0_s_val, fr1_s_val,
      output fl_ready, fr_next_angle_ack, fr_has_next_angle, fr_angle,
             fr0_val, fr1_val
   );
endinterface

// File: rtl/filtered_ram_swap_control_bank.sv
// One projection bank: single write port, two independent registered read ports.
module filtered_ram_bank #(
   parameter int DATA_W = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr0,
   input  logic [AW-1:0]     raddr1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1
);
   logic [DATA_W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read registers hold while the bank is not being read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else if (re) begin
         rdata0 <= mem[raddr0];
         rdata1 <= mem[raddr1];
      end
   end
endmodule

// File: rtl/filtered_ram_swap_control.sv
// Ping-pong filtered-projection store: filter fills one bank while processing
// reads the oldest complete angle from the other.
module filtered_ram_swap_control
   import filtered_ram_swap_control_pkg::*;
(
   input logic                         clk,
   input logic                         reset_n,
   filtered_ram_swap_control_if.slave  bus
);
   bank_state_e        state [2];
   logic [ANGLE_W-1:0] angle [2];
   logic               last  [2];
   logic               wr_ptr, rd_ptr, rd_oth, frame_open, rd_sel;
   logic [ANGLE_W-1:0] fr_angle_q;
   logic               fl_ready, wr_acc, done_acc, ack;
   logic [1:0]         we_b, re_b;
   logic [DATA_W-1:0]  rd0 [2];
   logic [DATA_W-1:0]  rd1 [2];

   assign rd_oth   = ~rd_ptr;
   assign fl_ready = (state[wr_ptr] == BANK_EMPTY) || (state[wr_ptr] == BANK_FILLING);
   assign wr_acc   = bus.fl_we && fl_ready;
   assign done_acc = bus.fl_done && fl_ready;
   assign ack      = bus.fr_next_angle && (state[rd_ptr] == BANK_FULL);

   assign we_b = {wr_acc & wr_ptr, wr_acc & ~wr_ptr};
   assign re_b = {state[1] == BANK_ACTIVE, state[0] == BANK_ACTIVE};

   // Ack and fill always touch different banks: the fill bank is never FULL.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            state[i] <= BANK_EMPTY;
            angle[i] <= '0;
            last[i]  <= 1'b0;
         end
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         frame_open <= 1'b0;
         fr_angle_q <= '0;
         rd_sel     <= 1'b0;
      end else begin
         if (ack) begin
            state[rd_ptr] <= BANK_ACTIVE;
            if (state[rd_oth] == BANK_ACTIVE) state[rd_oth] <= BANK_EMPTY;
            fr_angle_q <= angle[rd_ptr];
            rd_ptr     <= ~rd_ptr;
         end
         if (done_acc) begin
            state[wr_ptr] <= BANK_FULL;
            angle[wr_ptr] <= bus.fl_angle;
            last[wr_ptr]  <= bus.fl_last;
            wr_ptr        <= ~wr_ptr;
         end else if (wr_acc && state[wr_ptr] == BANK_EMPTY) begin
            state[wr_ptr] <= BANK_FILLING;
         end
         if (wr_acc || done_acc)         frame_open <= 1'b1;
         else if (ack && last[rd_ptr])   frame_open <= 1'b0;
         // Output mux follows whichever bank last refreshed its read registers.
         if (|re_b) rd_sel <= re_b[1];
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      filtered_ram_bank #(.DATA_W(DATA_W), .AW(S_W)) u_bank (
         .clk    (clk),
         .reset_n(reset_n),
         .we     (we_b[b]),
         .waddr  (s_to_addr(bus.fl_s)),
         .wdata  (bus.fl_val),
         .re     (re_b[b]),
         .raddr0 (s_to_addr(bus.fr0_s_val)),
         .raddr1 (s_to_addr(bus.fr1_s_val)),
         .rdata0 (rd0[b]),
         .rdata1 (rd1[b])
      );
   end

   assign bus.fl_ready          = fl_ready;
   assign bus.fr_next_angle_ack = ack;
   assign bus.fr_has_next_angle = frame_open ||
                                  (state[0] == BANK_FILLING) || (state[1] == BANK_FILLING) ||
                                  (state[0] == BANK_FULL)    || (state[1] == BANK_FULL);
   assign bus.fr_angle          = fr_angle_q;
   assign bus.fr0_val           = rd0[rd_sel];
   assign bus.fr1_val           = rd1[rd_sel];
endmodule

// File: tb/tb_filtered_ram_swap_control.sv
// Directed bench for the ping-pong filtered-projection store.
module tb_filtered_ram_swap_control;
   import filtered_ram_swap_control_pkg::*;

   logic clk;
   logic reset_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   filtered_ram_swap_control_if ifc ();

   filtered_ram_swap_control dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int s, input int v);
      ifc.fl_we  = 1'b1;
      ifc.fl_s   = S_W'(s);
      ifc.fl_val = DATA_W'(v);
      tick();
      ifc.fl_we  = 1'b0;
   endtask

   task automatic done(input int a, input bit l);
      ifc.fl_done  = 1'b1;
      ifc.fl_angle = ANGLE_W'(a);
      ifc.fl_last  = l;
      tick();
      ifc.fl_done  = 1'b0;
      ifc.fl_last  = 1'b0;
   endtask

   task automatic rst_pulse();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      ifc.fl_we = 0; ifc.fl_s = '0; ifc.fl_val = '0; ifc.fl_done = 0;
      ifc.fl_angle = '0; ifc.fl_last = 0; ifc.fr_next_angle = 0;
      ifc.fr0_s_val = '0; ifc.fr1_s_val = '0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state, then reset in the middle of a fill
      chk("rst_fl_ready", 32'(ifc.fl_ready), 1);
      chk("rst_has_next", 32'(ifc.fr_has_next_angle), 0);
      wr(5, 77);
      chk("t1_has_next_fill", 32'(ifc.fr_has_next_angle), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_fl_ready", 32'(ifc.fl_ready), 1);
      chk("t1_has_next", 32'(ifc.fr_has_next_angle), 0);
      chk("t1_fr_angle", 32'(ifc.fr_angle), 0);
      chk("t1_fr0_val", 32'(ifc.fr0_val), 0);
      chk("t1_fr1_val", 32'(ifc.fr1_val), 0);
      #1 reset_n = 1'b1;
      tick();

      // Single bank fill, ack, registered reads
      for (int s = -4; s <= 3; s++) wr(s, s * 3);
      done(30, 1'b0);
      chk("t2_ready_bank1", 32'(ifc.fl_ready), 1);
      ifc.fr_next_angle = 1'b1;
      #1 chk("t2_ack", 32'(ifc.fr_next_angle_ack), 1);
      tick();
      ifc.fr_next_angle = 1'b0;
      #1 chk("t2_ack_low", 32'(ifc.fr_next_angle_ack), 0);
      chk("t2_fr_angle", 32'(ifc.fr_angle), 30);
      ifc.fr0_s_val = -4; ifc.fr1_s_val = 3;
      tick();
      chk("t2_fr0_m4", 32'(ifc.fr0_val), -12);
      chk("t2_fr1_p3", 32'(ifc.fr1_val), 9);
      ifc.fr0_s_val = 0; ifc.fr1_s_val = -1;
      tick();
      chk("t2_fr0_0", 32'(ifc.fr0_val), 0);
      chk("t2_fr1_m1", 32'(ifc.fr1_val), -3);

      // Both banks full, dropped writes, two acks
      rst_pulse();
      wr(1, 11); done(10, 1'b0);
      wr(1, 22); done(20, 1'b0);
      chk("t3_ready_full", 32'(ifc.fl_ready), 0);
      chk("t3_has_next", 32'(ifc.fr_has_next_angle), 1);
      wr(1, 99); done(99, 1'b0);
      chk("t3_ready_drop", 32'(ifc.fl_ready), 0);
      ifc.fr_next_angle = 1'b1;
      #1 chk("t3_ack1", 32'(ifc.fr_next_angle_ack), 1);
      tick();
      ifc.fr_next_angle = 1'b0;
      chk("t3_angle10", 32'(ifc.fr_angle), 10);
      chk("t3_ready_act", 32'(ifc.fl_ready), 0);
      ifc.fr0_s_val = 1; ifc.fr1_s_val = 1;
      tick();
      chk("t3_rd0_b0", 32'(ifc.fr0_val), 11);
      chk("t3_rd1_b0", 32'(ifc.fr1_val), 11);
      ifc.fr_next_angle = 1'b1;
      #1 chk("t3_ack2", 32'(ifc.fr_next_angle_ack), 1);
      chk("t3_ready_pre", 32'(ifc.fl_ready), 0);
      tick();
      ifc.fr_next_angle = 1'b0;
      chk("t3_angle20", 32'(ifc.fr_angle), 20);
      chk("t3_ready_freed", 32'(ifc.fl_ready), 1);
      tick();
      chk("t3_rd0_b1", 32'(ifc.fr0_val), 22);

      // Request while the next bank is still filling
      wr(0, 7);
      ifc.fr_next_angle = 1'b1;
      #1 chk("t4_ack_filling", 32'(ifc.fr_next_angle_ack), 0);
      chk("t4_has_next", 32'(ifc.fr_has_next_angle), 1);
      tick();
      chk("t4_ack_wait", 32'(ifc.fr_next_angle_ack), 0);
      ifc.fl_done = 1'b1; ifc.fl_angle = 40;
      #1 chk("t4_ack_done_cyc", 32'(ifc.fr_next_angle_ack), 0);
      tick();
      ifc.fl_done = 1'b0;
      chk("t4_ack_after", 32'(ifc.fr_next_angle_ack), 1);
      tick();
      ifc.fr_next_angle = 1'b0;
      chk("t4_angle40", 32'(ifc.fr_angle), 40);
      ifc.fr0_s_val = 0;
      tick();
      chk("t4_rd0", 32'(ifc.fr0_val), 7);

      // Last angle of a frame, then a new frame
      wr(-8, -100); done(50, 1'b1);
      ifc.fr_next_angle = 1'b1;
      #1 chk("t5_ack_last", 32'(ifc.fr_next_angle_ack), 1);
      tick();
      ifc.fr_next_angle = 1'b0;
      chk("t5_has_next_end", 32'(ifc.fr_has_next_angle), 0);
      chk("t5_angle50", 32'(ifc.fr_angle), 50);
      chk("t5_ready", 32'(ifc.fl_ready), 1);
      ifc.fr0_s_val = -8;
      tick();
      chk("t5_rd_last", 32'(ifc.fr0_val), -100);
      wr(-8, 55);
      chk("t5_has_next_new", 32'(ifc.fr_has_next_angle), 1);
      chk("t5_old_readable", 32'(ifc.fr0_val), -100);
      wr(3, 66); done(60, 1'b0);
      tick();
      chk("t5_old_still", 32'(ifc.fr0_val), -100);
      ifc.fr_next_angle = 1'b1;
      #1 chk("t5_ack_new", 32'(ifc.fr_next_angle_ack), 1);
      tick();
      ifc.fr_next_angle = 1'b0;
      chk("t5_angle60", 32'(ifc.fr_angle), 60);
      ifc.fr1_s_val = 3;
      tick();
      chk("t5_rd0_new", 32'(ifc.fr0_val), 55);
      chk("t5_rd1_new", 32'(ifc.fr1_val), 66);

      // fl_done on bank 1 in the same cycle as the ack of bank 0
      rst_pulse();
      wr(-1, -9); done(70, 1'b0);
      wr(-1, 33);
      ifc.fl_done = 1'b1; ifc.fl_angle = 80; ifc.fr_next_angle = 1'b1;
      #1 chk("t6_ack", 32'(ifc.fr_next_angle_ack), 1);
      chk("t6_ready", 32'(ifc.fl_ready), 1);
      tick();
      ifc.fl_done = 1'b0; ifc.fr_next_angle = 1'b0;
      chk("t6_angle70", 32'(ifc.fr_angle), 70);
      chk("t6_ready_wr0", 32'(ifc.fl_ready), 0);
      chk("t6_has_next", 32'(ifc.fr_has_next_angle), 1);
      ifc.fr0_s_val = -1; ifc.fr_next_angle = 1'b1;
      #1 chk("t6_ack_b1", 32'(ifc.fr_next_angle_ack), 1);
      tick();
      ifc.fr_next_angle = 1'b0;
      chk("t6_angle80", 32'(ifc.fr_angle), 80);
      chk("t6_rd_b0", 32'(ifc.fr0_val), -9);
      chk("t6_ready_freed", 32'(ifc.fl_ready), 1);
      tick();
      chk("t6_rd_b1", 32'(ifc.fr0_val), 33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
